tile_mort_ibuf: RTL

TILE_MORT_IBUF -- requirements
Module: tile_mort_ibuf

---
 rtl/tile_mort_ibuf.sv | 112 +++++++++++
 1 files changed

// File: rtl/tile_mort_ibuf.sv
// Install buffer between the cluster fill FIFO and the cache install port.
// Fills to the same line coalesce into one pending entry; expunges queue in order.
module tile_mort_ibuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 37
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [527:0]      in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [41:0]       in_size,
  input  logic              in_expun,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [527:0]      wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [41:0]       wr_size,
  output logic              wr_expun,
  output logic [3:0]        count,
  output logic              full,
  output logic              ovf,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit
);

  localparam int PW = $clog2(DEPTH);

  logic [527:0]      data  [DEPTH];
  logic [ADDR_W-1:0] addr  [DEPTH];
  logic [41:0]       size  [DEPTH];
  logic [DEPTH-1:0]  expun;
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     k;
  logic [PW-1:0]     midx;
  logic              mhit;
  logic              pop;
  logic              alloc;
  logic              drop;

  assign full     = (count == 4'(DEPTH));
  assign wr_en    = valid[head];
  assign wr_data  = data[head];
  assign wr_addr  = addr[head];
  assign wr_size  = size[head];
  assign wr_expun = expun[head];
  assign pop      = wr_en && wr_ready;

  // Scan from just past head toward tail so the youngest match wins.
  always_comb begin
    mhit = 1'b0;
    midx = '0;
    k    = '0;
    for (int i = 1; i < DEPTH; i++) begin
      k = head + PW'(i);
      if (valid[k] && !expun[k] && addr[k] == in_addr) begin
        mhit = 1'b1;
        midx = k;
      end
    end
  end

  logic merge;
  assign merge = in_en && !in_expun && mhit;
  assign alloc = in_en && !merge && (!full || pop);
  assign drop  = in_en && !merge && full && !pop;

  always_comb begin
    lk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && !expun[i] && addr[i] == lk_addr)
        lk_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (drop)
        ovf <= 1'b1;
      count <= count + 4'(alloc) - 4'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      data[tail]  <= in_data;
      addr[tail]  <= in_addr;
      size[tail]  <= in_size;
      expun[tail] <= in_expun;
    end
    if (merge) begin
      data[midx] <= in_data;
      size[midx] <= {in_size[41:40], size[midx][39:0] | in_size[39:0]};
    end
  end

endmodule
